dnn_argmax_fix13: RTL and testbench



---
 rtl/dnn_fix_pkg.sv | 26 ++
 rtl/dnn_argmax_fix13_if.sv | 26 ++
 rtl/dnn_max2_update.sv | 29 ++
 rtl/dnn_argmax_fix13.sv | 141 ++++++++++++++
 tb/tb_dnn_argmax_fix13.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/dnn_fix_pkg.sv
// Shared types and constants for the 13-bit fixed-point classifier stage.
// Scores are signed with 1.0 = 13'sh0800.
package dnn_fix_pkg;

   localparam int DATA_WIDTH  = 13;
   localparam int NUM_CLASSES = 10;
   localparam int IDX_WIDTH   = 4;

   typedef logic signed [DATA_WIDTH-1:0] score_t;
   typedef logic        [DATA_WIDTH-1:0] margin_t;
   typedef logic        [IDX_WIDTH-1:0]  idx_t;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;

   localparam score_t SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam idx_t   LAST_IDX  = idx_t'(NUM_CLASSES-1);

   // One extra bit keeps the subtraction exact; max >= second, so the
   // non-negative result always fits back into DATA_WIDTH bits.
   function automatic margin_t score_margin(input score_t hi, input score_t lo);
      logic signed [DATA_WIDTH:0] diff;
      diff = (DATA_WIDTH+1)'(hi) - (DATA_WIDTH+1)'(lo);
      return margin_t'(diff);
   endfunction

endpackage

// File: rtl/dnn_argmax_fix13_if.sv
// Control and result bundle between the inference engine side and the
// argmax classifier; master drives start/reset/scores, slave returns results.
interface dnn_argmax_fix13_if;
   import dnn_fix_pkg::*;

   logic                      start;
   logic                      reset;
   score_t [NUM_CLASSES-1:0]  in_scores;
   logic                      busy;
   logic                      done;
   logic                      result_valid;
   idx_t                      class_idx;
   score_t                    class_val;
   margin_t                   margin;

   modport master (
      output start, reset, in_scores,
      input  busy, done, result_valid, class_idx, class_val, margin
   );

   modport slave (
      input  start, reset, in_scores,
      output busy, done, result_valid, class_idx, class_val, margin
   );

endinterface

// File: rtl/dnn_max2_update.sv
// Combinational running-max / runner-up update for one candidate score.
// Signed compares; ties never displace the current max (lowest index wins).
module dnn_max2_update
   import dnn_fix_pkg::*;
(
   input  score_t cur_max,
   input  idx_t   cur_idx,
   input  score_t cur_second,
   input  score_t value,
   input  idx_t   index,
   output score_t nxt_max,
   output idx_t   nxt_idx,
   output score_t nxt_second
);

   always_comb begin
      nxt_max    = cur_max;
      nxt_idx    = cur_idx;
      nxt_second = cur_second;
      if (value > cur_max) begin
         nxt_second = cur_max;
         nxt_max    = value;
         nxt_idx    = index;
      end else if (value > cur_second) begin
         nxt_second = value;
      end
   end

endmodule

// File: rtl/dnn_argmax_fix13.sv
// Argmax classifier: snapshots the score vector on start, scans one score per
// clock, then registers the winning index, its score and the margin.
module dnn_argmax_fix13
   import dnn_fix_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   dnn_argmax_fix13_if.slave  bus
);

   argmax_state_t            state_q, state_d;
   score_t [NUM_CLASSES-1:0] snap_q, snap_d;
   score_t                   max_q, max_d;
   idx_t                     max_idx_q, max_idx_d;
   score_t                   second_q, second_d;
   idx_t                     scan_idx_q, scan_idx_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     valid_q, valid_d;
   idx_t                     class_idx_q, class_idx_d;
   score_t                   class_val_q, class_val_d;
   margin_t                  margin_q, margin_d;

   score_t upd_max, upd_second;
   idx_t   upd_idx;

   dnn_max2_update u_max2 (
      .cur_max    (max_q),
      .cur_idx    (max_idx_q),
      .cur_second (second_q),
      .value      (snap_q[scan_idx_q]),
      .index      (scan_idx_q),
      .nxt_max    (upd_max),
      .nxt_idx    (upd_idx),
      .nxt_second (upd_second)
   );

   always_comb begin
      // NOTE: every _d gets its hold value first so no path can infer a latch.
      state_d     = state_q;
      snap_d      = snap_q;
      max_d       = max_q;
      max_idx_d   = max_idx_q;
      second_d    = second_q;
      scan_idx_d  = scan_idx_q;
      done_d      = 1'b0;
      valid_d     = valid_q;
      class_idx_d = class_idx_q;
      class_val_d = class_val_q;
      margin_d    = margin_q;

      if (bus.reset) begin
         state_d     = IDLE;
         snap_d      = '0;
         max_d       = '0;
         max_idx_d   = '0;
         second_d    = '0;
         scan_idx_d  = '0;
         valid_d     = 1'b0;
         class_idx_d = '0;
         class_val_d = '0;
         margin_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  snap_d     = bus.in_scores;
                  max_d      = bus.in_scores[0];
                  max_idx_d  = '0;
                  second_d   = SCORE_MIN;
                  scan_idx_d = idx_t'(1);
                  valid_d    = 1'b0;
                  state_d    = SCAN;
               end
            end
            SCAN: begin
               max_d     = upd_max;
               max_idx_d = upd_idx;
               second_d  = upd_second;
               if (scan_idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  scan_idx_d = scan_idx_q + idx_t'(1);
               end
            end
            DONE: begin
               done_d      = 1'b1;
               valid_d     = 1'b1;
               class_idx_d = max_idx_q;
               class_val_d = max_q;
               margin_d    = score_margin(max_q, second_q);
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d == SCAN);
   end

   // NOTE: the snapshot is only ten words of flops, so it is reset along with
   // everything else; outputs and internal state are then fully defined.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         snap_q      <= '0;
         max_q       <= '0;
         max_idx_q   <= '0;
         second_q    <= '0;
         scan_idx_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
         class_idx_q <= '0;
         class_val_q <= '0;
         margin_q    <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         state_q     <= state_d;
         snap_q      <= snap_d;
         max_q       <= max_d;
         max_idx_q   <= max_idx_d;
         second_q    <= second_d;
         scan_idx_q  <= scan_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         valid_q     <= valid_d;
         class_idx_q <= class_idx_d;
         class_val_q <= class_val_d;
         margin_q    <= margin_d;
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.result_valid = valid_q;
   assign bus.class_idx    = class_idx_q;
   assign bus.class_val    = class_val_q;
   assign bus.margin       = margin_q;

endmodule

// File: tb/tb_dnn_argmax_fix13.sv
// Directed self-checking bench for dnn_argmax_fix13: inputs driven and
// outputs sampled on the falling clock edge.
module tb_dnn_argmax_fix13;
   import dnn_fix_pkg::*;

   localparam int LAT = 10;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   dnn_argmax_fix13_if bus ();

   dnn_argmax_fix13 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DATA_WIDTH-1:0] got,
                        input logic [DATA_WIDTH-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   task automatic fill(input score_t base);
      for (int i = 0; i < NUM_CLASSES; i++) bus.in_scores[i] = base;
   endtask

   // Pulse start for one edge; returns at the falling edge just after it.
   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int k;
      k = 0;
      while (!bus.done && k < 4*LAT) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_latency"}, DATA_WIDTH'(k), DATA_WIDTH'(exp_lat));
   endtask

   task automatic check_result(input string tag, input idx_t idx,
                               input score_t val, input margin_t mar);
      check({tag, "_done"},  DATA_WIDTH'(bus.done), 1);
      check({tag, "_valid"}, DATA_WIDTH'(bus.result_valid), 1);
      check({tag, "_idx"},   DATA_WIDTH'(bus.class_idx), DATA_WIDTH'(idx));
      check({tag, "_val"},   bus.class_val, val);
      check({tag, "_margin"}, bus.margin, mar);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_busy"},   DATA_WIDTH'(bus.busy), 0);
      check({tag, "_valid"},  DATA_WIDTH'(bus.result_valid), 0);
      check({tag, "_done"},   DATA_WIDTH'(bus.done), 0);
      check({tag, "_idx"},    DATA_WIDTH'(bus.class_idx), 0);
      check({tag, "_val"},    bus.class_val, 0);
      check({tag, "_margin"}, bus.margin, 0);
   endtask

   task automatic load_distinct();
      fill(13'sh0010);
      bus.in_scores[7] = 13'sh07F0;
      bus.in_scores[2] = 13'sh0600;
   endtask

   initial begin
      int dcount;
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.reset = 1'b0;
      fill(13'sh0000);
      repeat (3) @(negedge clk);
      check_cleared("por");
      rst = 1'b1;
      @(negedge clk);
      check_cleared("por_release");

      // Distinct scores: max at 7, runner-up at 2.
      load_distinct();
      pulse_start();
      check("t1_busy", DATA_WIDTH'(bus.busy), 1);
      wait_done("t1", LAT);
      check_result("t1", 4'd7, 13'sh07F0, 13'h01F0);
      @(negedge clk);
      check("t1_done_pulse", DATA_WIDTH'(bus.done), 0);
      check("t1_valid_hold", DATA_WIDTH'(bus.result_valid), 1);

      // Tie between 3 and 8: lowest index wins, margin 0.
      fill(13'sh0000);
      bus.in_scores[3] = 13'sh0800;
      bus.in_scores[8] = 13'sh0800;
      pulse_start();
      wait_done("t2", LAT);
      check_result("t2", 4'd3, 13'sh0800, 13'h0000);

      // All negative.
      fill(-13'sd4096);
      bus.in_scores[0] = -13'sd5;
      bus.in_scores[9] = -13'sd1;
      pulse_start();
      wait_done("t3", LAT);
      check_result("t3", 4'd9, -13'sd1, 13'h0004);

      // Re-pulsed start while scanning and in DONE; inputs change after start.
      load_distinct();
      pulse_start();
      fill(13'sh0FFF);
      dcount = 0;
      for (int k = 1; k <= 25; k++) begin
         bus.start = ((k-1) == 3) || ((k-1) == 9);
         @(negedge clk);
         if (bus.done) begin
            dcount++;
            if (k == LAT) check_result("t4", 4'd7, 13'sh07F0, 13'h01F0);
         end
      end
      bus.start = 1'b0;
      check("t4_done_count", DATA_WIDTH'(dcount), 1);
      check("t4_idle", DATA_WIDTH'(bus.busy), 0);
      check("t4_idx_held", DATA_WIDTH'(bus.class_idx), 7);

      // Soft reset mid-scan.
      fill(13'sh0000);
      bus.in_scores[5] = 13'sh0123;
      pulse_start();
      check("t5_valid_drop", DATA_WIDTH'(bus.result_valid), 0);
      check("t5_idx_kept", DATA_WIDTH'(bus.class_idx), 7);
      repeat (5) @(negedge clk);
      bus.reset = 1'b1;
      @(negedge clk);
      bus.reset = 1'b0;
      check_cleared("t5_sreset");
      pulse_start();
      wait_done("t5b", LAT);
      check_result("t5b", 4'd5, 13'sh0123, 13'h0123);

      // Asynchronous reset mid-scan clears without waiting for an edge.
      fill(-13'sd4096);
      bus.in_scores[0] = -13'sd5;
      bus.in_scores[9] = -13'sd1;
      pulse_start();
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1 check_cleared("t6_areset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      load_distinct();
      pulse_start();
      wait_done("t6b", LAT);
      check_result("t6b", 4'd7, 13'sh07F0, 13'h01F0);

      // Back-to-back: start in the first IDLE cycle after done.
      fill(13'sh0000);
      bus.in_scores[0] = 13'sh0100;
      pulse_start();
      repeat (5) @(negedge clk);
      check("t7_idx_held", DATA_WIDTH'(bus.class_idx), 7);
      check("t7_val_held", bus.class_val, 13'sh07F0);
      wait_done("t7", LAT - 5);
      check_result("t7", 4'd0, 13'sh0100, 13'h0100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
